// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The fetch stage drives the address and read enable. Memory answers
// combinationally in the same cycle.
interface if_stage_if;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic [15:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage.
// Holds the fetch PC and the IF/ID pipeline register.
// Edge priority, highest first: reset, redirect, stall, halted, normal fetch.
// An HLT opcode freezes the PC on the instruction that carries it.
// Fetch then stays frozen until a redirect or a reset.
module if_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    if_stage_if.master  imem,
    output logic [15:0] pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] fetch_cnt
);

    logic [15:0] pc_plus2;
    logic        is_hlt;
    logic [15:0] cnt_next;

    // The next sequential address wraps modulo 2^16.
    assign pc_plus2 = pc + 16'd2;
    assign is_hlt   = (imem.imem_rdata[15:12] == HLT_OPCODE);
    // The fetch counter sticks at all-ones instead of wrapping.
    assign cnt_next = (fetch_cnt == 16'hFFFF) ? fetch_cnt : fetch_cnt + 16'd1;

    assign imem.imem_addr = pc;
    assign imem.imem_en   = ~rst & ~halted;

    // PC, IF/ID register, halt flag and fetch counter, in edge-priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            ifid_instr    <= 16'h0000;
            ifid_pc_plus2 <= 16'h0000;
            ifid_valid    <= 1'b0;
            halted        <= 1'b0;
            fetch_cnt     <= 16'h0000;
        end else if (branch_taken) begin
            // A redirect wins over stall and halt.
            // It leaves a bubble in IF/ID and resumes fetch.
            pc         <= branch_target;
            ifid_instr <= 16'h0000;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
        end else if (stall) begin
            // Everything holds.
            // An HLT sitting on the bus is seen again after the stall releases.
        end else if (halted) begin
            ifid_valid <= 1'b0;
        end else begin
            ifid_instr    <= imem.imem_rdata;
            ifid_pc_plus2 <= pc_plus2;
            ifid_valid    <= 1'b1;
            fetch_cnt     <= cnt_next;
            if (is_hlt) begin
                halted <= 1'b1;
            end else begin
                pc <= pc_plus2;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage.
// Directed scenarios with literal expectations come first, then randomized stimulus.
// A behavioural model tracks the expected state.
// A negedge process compares every DUT output against it.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_cnt;

    if_stage_if imem ();

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .fetch_cnt     (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Model state.
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_pp2;
    logic        m_valid;
    logic        m_halted;
    logic [15:0] m_cnt;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the current inputs.
    // Then let the DUT clock and settle past the following negedge.
    task automatic cycle();
        logic [15:0] rd;
        rd = imem.imem_rdata;
        if (rst) begin
            m_pc = 16'h0000; m_instr = 16'h0000; m_pp2 = 16'h0000;
            m_valid = 1'b0; m_halted = 1'b0; m_cnt = 16'h0000;
        end else if (branch_taken) begin
            m_pc = branch_target; m_valid = 1'b0; m_instr = 16'h0000; m_halted = 1'b0;
        end else if (stall) begin
            // no change
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else begin
            m_instr = rd;
            m_pp2   = m_pc + 16'd2;
            m_valid = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (rd[15:12] == 4'hF) m_halted = 1'b1;
            else m_pc = m_pc + 16'd2;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", imem.imem_addr, m_pc);
            chk("imem_en", {15'd0, imem.imem_en}, {15'd0, (~rst & ~m_halted)});
            chk("ifid_instr", ifid_instr, m_instr);
            chk("ifid_pc_plus2", ifid_pc_plus2, m_pp2);
            chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
            chk("halted", {15'd0, halted}, {15'd0, m_halted});
            chk("fetch_cnt", fetch_cnt, m_cnt);
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        imem.imem_rdata = 16'h0000;
        @(negedge clk);
        cycle();
        chk_en = 1'b1;
        // Reset state. rst is still high here, so imem_en must be 0.
        chk("rst pc", pc, 16'h0000);
        chk("rst valid", {15'd0, ifid_valid}, 16'h0000);
        chk("rst instr", ifid_instr, 16'h0000);
        chk("rst cnt", fetch_cnt, 16'h0000);
        chk("rst imem_en", {15'd0, imem.imem_en}, 16'h0000);

        // Three sequential fetches of 1234.
        rst = 1'b0; imem.imem_rdata = 16'h1234;
        chk("first fetch addr", imem.imem_addr, 16'h0000);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("seq pc", pc, 16'(2 * i));
            chk("seq pp2", ifid_pc_plus2, 16'(2 * i));
        end
        chk("seq cnt", fetch_cnt, 16'd3);

        // Two-cycle stall holds PC, IF/ID and the counter.
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("stall pc", pc, 16'h0006);
            chk("stall pp2", ifid_pc_plus2, 16'h0006);
            chk("stall cnt", fetch_cnt, 16'd3);
        end
        stall = 1'b0;
        cycle();
        chk("resume pc", pc, 16'h0008);

        // A redirect during a stall still takes effect.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
        cycle();
        chk("br pc", pc, 16'h0040);
        chk("br valid", {15'd0, ifid_valid}, 16'h0000);
        chk("br instr", ifid_instr, 16'h0000);
        stall = 1'b0;

        // HLT fetched at 0010.
        branch_target = 16'h0010;
        cycle();
        branch_taken = 1'b0; imem.imem_rdata = 16'hF000;
        cycle();
        chk("hlt instr", ifid_instr, 16'hF000);
        chk("hlt valid", {15'd0, ifid_valid}, 16'h0001);
        chk("hlt pc", pc, 16'h0010);
        chk("hlt halted", {15'd0, halted}, 16'h0001);
        chk("hlt imem_en", {15'd0, imem.imem_en}, 16'h0000);
        cycle();
        chk("hlt bubble", {15'd0, ifid_valid}, 16'h0000);
        chk("hlt pc hold", pc, 16'h0010);
        branch_taken = 1'b1; branch_target = 16'h0020;
        cycle();
        chk("unhalt", {15'd0, halted}, 16'h0000);
        chk("unhalt pc", pc, 16'h0020);

        // PC wraps modulo 2^16.
        branch_target = 16'hFFFE;
        cycle();
        branch_taken = 1'b0; imem.imem_rdata = 16'h1234;
        cycle();
        chk("wrap pc", pc, 16'h0000);
        chk("wrap pp2", ifid_pc_plus2, 16'h0000);

        // A stall over an HLT holds all state. The HLT is caught once the stall drops.
        stall = 1'b1; imem.imem_rdata = 16'hF123;
        cycle();
        chk("stall hlt halted", {15'd0, halted}, 16'h0000);
        chk("stall hlt pc", pc, 16'h0000);
        stall = 1'b0;
        cycle();
        chk("hlt after stall", {15'd0, halted}, 16'h0001);

        // Reset while halted and stalled.
        stall = 1'b1; rst = 1'b1;
        cycle();
        chk("rst halt pc", pc, 16'h0000);
        chk("rst halt halted", {15'd0, halted}, 16'h0000);
        chk("rst halt cnt", fetch_cnt, 16'h0000);
        chk("rst halt pp2", ifid_pc_plus2, 16'h0000);
        chk("rst halt instr", ifid_instr, 16'h0000);
        rst = 1'b0; stall = 1'b0;

        // Randomized stimulus.
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 39) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = 16'($urandom);
            if ($urandom_range(0, 7) == 0)
                imem.imem_rdata = {4'hF, 12'($urandom)};
            else
                imem.imem_rdata = 16'($urandom);
            cycle();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
